fault_monitor: RTL and testbench
================================

// Module: fault_monitor
// PURPOSE
//  Sequential, multi-lane successor to fault_detector. Checks NUM_CH redundant decoder control bundles
//  (opcode, reg_write, mem_read, mem_write) each valid cycle for invalid opcode, illegal control and
//  lane disagreement. Filters transients with a persistence FSM, latches sticky fault status and
//  requests core recovery. Sits beside the decode stage of the fault-tolerant CPU.
// PARAMETERS
//  NUM_CH     2  redundant lanes checked (1..4); NUM_CH=1 disables mismatch check
//  PERSIST    2  consecutive faulty valid cycles needed to declare FAULT (>=1)
//  RECOV_CYC  4  consecutive clean valid cycles in RECOVER before returning to OK (>=1)
//  CNT_W      8  width of saturating fault-event counter
// PORTS
//  clk              in   1          system clock, rising edge
//  rst_n            in   1          synchronous, active-low reset
//  valid_i          in   1          control bundle valid this cycle
//  opcode_i         in   7*NUM_CH   lane k opcode at [7k+6:7k]
//  reg_write_i      in   NUM_CH     per-lane reg_write
//  mem_read_i       in   NUM_CH     per-lane mem_read
//  mem_write_i      in   NUM_CH     per-lane mem_write
//  clear_i          in   1          software clear / recovery acknowledge
//  fault_detected_o out  1          high while state==FAULT
//  fault_code_o     out  3          latched type mask: [0] bad opcode, [1] illegal ctrl, [2] mismatch
//  fault_lane_o     out  2          latched lowest offending lane index
//  fault_count_o    out  CNT_W      saturating count of raw-faulty valid cycles
//  state_o          out  2          FSM state (OK=0, SUSPECT=1, FAULT=2, RECOVER=3)
//  recover_req_o    out  1          one-cycle pulse on entry to FAULT
// BEHAVIOUR
//  Reset (rst_n=0 at edge): state OK, all outputs 0, persistence/recovery counters 0, raw stage 0.
//  Raw check (combinational, per lane), registered once -> raw_q, valid_q (1-cycle latency):
//   - bad opcode: not in {0110011,0010011,0000011,0100011,1100011,1101111,1100111,0110111,0010111,1110011}
//   - illegal ctrl: (mem_read&mem_write) | (mem_read & opcode!=0000011) | (mem_write & opcode!=0100011)
//   - mismatch: any lane k>0 bundle != lane 0 bundle; offending lane = lowest such k
//   - raw fault = valid_i & OR of all types; checks ignored when valid_i=0
//  Lane report: lowest lane with bad opcode/illegal ctrl; else lowest mismatching lane.
//  FSM (advances only on valid_q=1; valid_q=0 holds state and all counters):
//   OK:      raw_q -> run=1; PERSIST==1 ? FAULT : SUSPECT
//   SUSPECT: raw_q -> run+1; run reaches PERSIST -> FAULT; clean -> OK, run=0 (transient)
//   FAULT:   sticky; clear_i (any valid_q) -> RECOVER, clean_run=0
//   RECOVER: clean -> clean_run+1, reaching RECOV_CYC -> OK; raw_q -> FAULT (no persistence filter)
//  clear_i is evaluated every cycle regardless of valid_q.
//  Latch: fault_code_o/fault_lane_o capture on entry to FAULT from first faulty cycle of that run.
//   Frozen while FAULT; zeroed on RECOVER->OK exit only.
//  Latency: PERSIST=2, faulty inputs sampled at edges E1,E2 -> fault_detected_o high after E3.
//  recover_req_o: high exactly the cycle after each transition into FAULT (incl. RECOVER->FAULT).
//  fault_count_o: +1 per raw-faulty valid cycle in any state, saturates at 2^CNT_W-1, never wraps.
//   clear_i zeroes it; same-cycle raw fault with clear_i -> count=1 (clear then count).
//  Simultaneous in FAULT: clear_i wins -> RECOVER; a raw fault in the next valid cycle returns to FAULT.
//  clear_i in OK/SUSPECT: clears count only, state unchanged.
//  Reset mid-operation: reset dominates all inputs; in-flight raw_q discarded.
// STRUCTURE
//  fault_pkg (`include header): opcode localparams, fault-type bit positions, FSM state encodings.
//  fault_check_lane: combinational per-lane bad-opcode / illegal-ctrl check, instantiated NUM_CH times
//   via generate. Mismatch compare, priority encode, FSM and counters stay in fault_monitor.
// TESTING
//  1 R-type 0110011, rw=1, mr=mw=0, both lanes equal, 20 cycles -> state OK, count 0, no fault.
//  2 One cycle opcode 1111111 on lane 0 then clean -> SUSPECT one cycle, back to OK, count=1,
//    fault_detected_o never high.
//  3 Load 0000011 rw=mr=mw=1 on both lanes for 2 valid cycles -> FAULT after 3rd edge, code=010,
//    lane=0, one recover_req_o pulse.
//  4 Lane 1 opcode 0010011 vs lane 0 0110011, 2 cycles -> FAULT, code=100, lane=1;
//    clear_i -> RECOVER; 4 clean cycles -> OK, code/lane 0.
//  5 In RECOVER inject one bad opcode -> FAULT next edge, recover_req_o pulses again.
//  6 CNT_W=2, 5 faulty cycles -> count saturates at 3; valid_i=0 gaps hold state;
//    rst_n=0 mid-SUSPECT -> all outputs 0 next edge.

Source files
------------

// File: rtl/fault_pkg.sv
// Shared definitions for the fault monitor: the legal opcode set, the bit
// positions of the fault-type mask and the supervisor FSM state encoding.
package fault_pkg;

  // Opcodes the decoder is allowed to produce
  localparam logic [6:0] OP_R_TYPE = 7'b0110011;
  localparam logic [6:0] OP_I_TYPE = 7'b0010011;
  localparam logic [6:0] OP_LOAD   = 7'b0000011;
  localparam logic [6:0] OP_STORE  = 7'b0100011;
  localparam logic [6:0] OP_BRANCH = 7'b1100011;
  localparam logic [6:0] OP_JAL    = 7'b1101111;
  localparam logic [6:0] OP_JALR   = 7'b1100111;
  localparam logic [6:0] OP_LUI    = 7'b0110111;
  localparam logic [6:0] OP_AUIPC  = 7'b0010111;
  localparam logic [6:0] OP_SYSTEM = 7'b1110011;

  // Fault-type mask layout
  localparam int FT_W        = 3;
  localparam int FT_BAD_OP   = 0;
  localparam int FT_ILL_CTRL = 1;
  localparam int FT_MISMATCH = 2;

  typedef enum logic [1:0] {
    ST_OK      = 2'd0,
    ST_SUSPECT = 2'd1,
    ST_FAULT   = 2'd2,
    ST_RECOVER = 2'd3
  } state_t;

  function automatic logic is_known_opcode(input logic [6:0] op);
    logic known;
    case (op)
      OP_R_TYPE, OP_I_TYPE, OP_LOAD, OP_STORE, OP_BRANCH,
      OP_JAL, OP_JALR, OP_LUI, OP_AUIPC, OP_SYSTEM: known = 1'b1;
      default:                                      known = 1'b0;
    endcase
    return known;
  endfunction

endpackage

// File: rtl/fault_check_lane.sv
// Per-lane combinational sanity check of one decoder control bundle:
// flags an opcode outside the legal set and memory controls that contradict
// the opcode (or each other).
module fault_check_lane
  import fault_pkg::*;
(
  input  logic [6:0] i_opcode,
  input  logic       i_mem_read,
  input  logic       i_mem_write,
  output logic       o_bad_opcode,
  output logic       o_illegal_ctrl
);

  assign o_bad_opcode   = !is_known_opcode(i_opcode);
  assign o_illegal_ctrl = (i_mem_read && i_mem_write)
                        || (i_mem_read  && (i_opcode != OP_LOAD))
                        || (i_mem_write && (i_opcode != OP_STORE));

endmodule

// File: rtl/fault_monitor.sv
// Fault monitor for redundant decoder lanes. Raw per-cycle checks are
// registered once, then a persistence FSM filters transients, latches the
// fault type/lane of the run that caused the fault and pulses a recovery
// request. A saturating counter tallies every raw-faulty valid cycle.
module fault_monitor
  import fault_pkg::*;
#(
  parameter int NUM_CH    = 2,
  parameter int PERSIST   = 2,
  parameter int RECOV_CYC = 4,
  parameter int CNT_W     = 8
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  valid_i,
  input  logic [7*NUM_CH-1:0]   opcode_i,
  input  logic [NUM_CH-1:0]     reg_write_i,
  input  logic [NUM_CH-1:0]     mem_read_i,
  input  logic [NUM_CH-1:0]     mem_write_i,
  input  logic                  clear_i,
  output logic                  fault_detected_o,
  output logic [FT_W-1:0]       fault_code_o,
  output logic [1:0]            fault_lane_o,
  output logic [CNT_W-1:0]      fault_count_o,
  output logic [1:0]            state_o,
  output logic                  recover_req_o
);

  localparam int RUN_W = $clog2(PERSIST + 1);
  localparam int REC_W = $clog2(RECOV_CYC + 1);
  localparam logic [RUN_W-1:0] PERSIST_V = RUN_W'(PERSIST);
  localparam logic [REC_W-1:0] RECOV_V   = REC_W'(RECOV_CYC);

  // Per-lane check results
  logic [NUM_CH-1:0] w_bad;
  logic [NUM_CH-1:0] w_ill;
  logic [NUM_CH-1:0] w_hit;
  logic [NUM_CH-1:0] w_mis;
  logic [1:0]        w_chk_lane;
  logic [1:0]        w_mis_lane;
  logic [FT_W-1:0]   w_raw_code;
  logic [1:0]        w_raw_lane;

  // Registered raw stage
  logic [FT_W-1:0]   r_raw_code;
  logic [1:0]        r_raw_lane;
  logic              r_valid_q;
  logic              w_raw_fault;

  // Supervisor state
  state_t            r_state;
  logic [RUN_W-1:0]  r_run;
  logic [REC_W-1:0]  r_clean_run;
  logic [RUN_W-1:0]  w_run_next;
  logic [REC_W-1:0]  w_clean_next;
  logic [FT_W-1:0]   r_first_code;
  logic [1:0]        r_first_lane;
  logic [FT_W-1:0]   r_code;
  logic [1:0]        r_lane;
  logic              r_recover_req;
  logic [CNT_W-1:0]  r_count;

  for (genvar g = 0; g < NUM_CH; g++) begin : g_lane
    fault_check_lane u_check (
      .i_opcode       (opcode_i[7*g +: 7]),
      .i_mem_read     (mem_read_i[g]),
      .i_mem_write    (mem_write_i[g]),
      .o_bad_opcode   (w_bad[g]),
      .o_illegal_ctrl (w_ill[g])
    );
  end

  assign w_hit = w_bad | w_ill;

  // Cross-lane compare and lane priority encode; lowest offending lane wins
  // NOTE: every output of this block gets a default first so no path leaves it unassigned, which would infer a latch.
  always_comb begin
    w_mis      = '0;
    w_mis_lane = '0;
    w_chk_lane = '0;
    w_raw_code = '0;
    w_raw_lane = '0;
    for (int k = NUM_CH - 1; k >= 1; k--) begin
      if ({opcode_i[7*k +: 7], reg_write_i[k], mem_read_i[k], mem_write_i[k]} !=
          {opcode_i[6:0], reg_write_i[0], mem_read_i[0], mem_write_i[0]}) begin
        w_mis[k]   = 1'b1;
        w_mis_lane = 2'(k);
      end
    end
    for (int k = NUM_CH - 1; k >= 0; k--) begin
      if (w_hit[k]) w_chk_lane = 2'(k);
    end
    if (valid_i) begin
      w_raw_code[FT_BAD_OP]   = |w_bad;
      w_raw_code[FT_ILL_CTRL] = |w_ill;
      w_raw_code[FT_MISMATCH] = |w_mis;
      w_raw_lane              = (|w_hit) ? w_chk_lane : w_mis_lane;
    end
  end

  // Register the raw check once; the FSM works from this stage
  // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_raw_code <= '0;
      r_raw_lane <= '0;
      r_valid_q  <= 1'b0;
    end else begin
      r_raw_code <= w_raw_code;
      r_raw_lane <= w_raw_lane;
      r_valid_q  <= valid_i;
    end
  end

  // Raw code is already gated by valid, so any set bit is a faulty valid cycle
  assign w_raw_fault  = |r_raw_code;
  assign w_run_next   = r_run + RUN_W'(1);
  assign w_clean_next = r_clean_run + REC_W'(1);

  // Saturating fault-event counter; clear takes effect before this cycle's count
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_count <= '0;
    end else if (clear_i) begin
      r_count <= CNT_W'(w_raw_fault);
    end else if (w_raw_fault && (r_count != {CNT_W{1'b1}})) begin
      r_count <= r_count + CNT_W'(1);
    end
  end

  // Persistence / recovery FSM with sticky fault latch and recovery pulse
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_state       <= ST_OK;
      r_run         <= '0;
      r_clean_run   <= '0;
      r_first_code  <= '0;
      r_first_lane  <= '0;
      r_code        <= '0;
      r_lane        <= '0;
      r_recover_req <= 1'b0;
    end else begin
      r_recover_req <= 1'b0;
      case (r_state)
        ST_OK: begin
          if (w_raw_fault) begin
            r_run        <= RUN_W'(1);
            r_first_code <= r_raw_code;
            r_first_lane <= r_raw_lane;
            if (PERSIST == 1) begin
              r_state       <= ST_FAULT;
              r_recover_req <= 1'b1;
              r_code        <= r_raw_code;
              r_lane        <= r_raw_lane;
            end else begin
              r_state <= ST_SUSPECT;
            end
          end
        end
        ST_SUSPECT: begin
          if (r_valid_q) begin
            if (w_raw_fault) begin
              r_run <= w_run_next;
              if (w_run_next >= PERSIST_V) begin
                r_state       <= ST_FAULT;
                r_recover_req <= 1'b1;
                r_code        <= r_first_code;
                r_lane        <= r_first_lane;
              end
            end else begin
              r_state <= ST_OK;
              r_run   <= '0;
            end
          end
        end
        ST_FAULT: begin
          if (clear_i) begin
            r_state     <= ST_RECOVER;
            r_clean_run <= '0;
          end
        end
        ST_RECOVER: begin
          if (r_valid_q) begin
            if (w_raw_fault) begin
              // No persistence filter while recovering
              r_state       <= ST_FAULT;
              r_recover_req <= 1'b1;
              r_code        <= r_raw_code;
              r_lane        <= r_raw_lane;
            end else begin
              r_clean_run <= w_clean_next;
              if (w_clean_next >= RECOV_V) begin
                r_state <= ST_OK;
                r_run   <= '0;
                r_code  <= '0;
                r_lane  <= '0;
              end
            end
          end
        end
        default: r_state <= ST_OK;
      endcase
    end
  end

  assign fault_detected_o = (r_state == ST_FAULT);
  assign fault_code_o     = r_code;
  assign fault_lane_o     = r_lane;
  assign fault_count_o    = r_count;
  assign state_o          = r_state;
  assign recover_req_o    = r_recover_req;

endmodule

// File: tb/tb_fault_monitor.sv
// Self-checking bench for fault_monitor: two lanes, PERSIST=2, RECOV_CYC=4,
// CNT_W=2. A rule-level reference model is compared against the DUT every
// cycle, with hand-computed literal checks at the key points.
module tb_fault_monitor;

  localparam int NUM_CH    = 2;
  localparam int PERSIST   = 2;
  localparam int RECOV_CYC = 4;
  localparam int CNT_W     = 2;
  localparam int CNT_MAX   = (1 << CNT_W) - 1;

  localparam logic [6:0] R  = 7'b0110011;
  localparam logic [6:0] I  = 7'b0010011;
  localparam logic [6:0] LD = 7'b0000011;
  localparam logic [6:0] XX = 7'b1111111;

  logic                clk = 1'b0;
  logic                rst_n;
  logic                valid_i;
  logic [7*NUM_CH-1:0] opcode_i;
  logic [NUM_CH-1:0]   reg_write_i;
  logic [NUM_CH-1:0]   mem_read_i;
  logic [NUM_CH-1:0]   mem_write_i;
  logic                clear_i;
  logic                fault_detected_o;
  logic [2:0]          fault_code_o;
  logic [1:0]          fault_lane_o;
  logic [CNT_W-1:0]    fault_count_o;
  logic [1:0]          state_o;
  logic                recover_req_o;

  int n_vec  = 0;
  int n_miss = 0;
  logic chk_en = 1'b0;

  fault_monitor #(
    .NUM_CH(NUM_CH), .PERSIST(PERSIST), .RECOV_CYC(RECOV_CYC), .CNT_W(CNT_W)
  ) dut (
    .clk              (clk),
    .rst_n            (rst_n),
    .valid_i          (valid_i),
    .opcode_i         (opcode_i),
    .reg_write_i      (reg_write_i),
    .mem_read_i       (mem_read_i),
    .mem_write_i      (mem_write_i),
    .clear_i          (clear_i),
    .fault_detected_o (fault_detected_o),
    .fault_code_o     (fault_code_o),
    .fault_lane_o     (fault_lane_o),
    .fault_count_o    (fault_count_o),
    .state_o          (state_o),
    .recover_req_o    (recover_req_o)
  );

  always #5 clk = ~clk;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_miss++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  // ---------------- reference model (rule level) ----------------
  int         m_state, m_run, m_clean, m_count;
  logic [2:0] m_code, m_first_code, m_pcode;
  logic [1:0] m_lane, m_first_lane, m_plane;
  logic       m_pv, m_req;

  // Classify one bundle set straight from the fault rules
  function automatic void classify(input logic v, input logic [13:0] op, input logic [1:0] rw,
                                   input logic [1:0] mr, input logic [1:0] mw,
                                   output logic [2:0] code, output logic [1:0] lane);
    logic [6:0] legal [10];
    logic [6:0] o;
    logic       known, bad, ill;
    int         hit_lane, mis_lane;
    legal = '{7'b0110011, 7'b0010011, 7'b0000011, 7'b0100011, 7'b1100011,
              7'b1101111, 7'b1100111, 7'b0110111, 7'b0010111, 7'b1110011};
    hit_lane = -1;
    mis_lane = -1;
    code = '0;
    lane = '0;
    if (v) begin
      for (int k = 0; k < NUM_CH; k++) begin
        o = op[7*k +: 7];
        known = 1'b0;
        for (int j = 0; j < 10; j++) if (legal[j] == o) known = 1'b1;
        bad = !known;
        ill = (mr[k] && mw[k]) || (mr[k] && o != 7'b0000011) || (mw[k] && o != 7'b0100011);
        if (bad) code[0] = 1'b1;
        if (ill) code[1] = 1'b1;
        if ((bad || ill) && hit_lane < 0) hit_lane = k;
        if (k > 0 && {o, rw[k], mr[k], mw[k]} != {op[6:0], rw[0], mr[0], mw[0]}) begin
          code[2] = 1'b1;
          if (mis_lane < 0) mis_lane = k;
        end
      end
      if (hit_lane >= 0)      lane = 2'(hit_lane);
      else if (mis_lane >= 0) lane = 2'(mis_lane);
    end
  endfunction

  task automatic enter_fault(input logic [2:0] c, input logic [1:0] l);
    m_state = 2;
    m_req   = 1'b1;
    m_code  = c;
    m_lane  = l;
  endtask

  // Advance the model by one clock edge using the inputs held across it
  task automatic model_step();
    logic f;
    logic [2:0] nc;
    logic [1:0] nl;
    if (!rst_n) begin
      m_state = 0; m_run = 0; m_clean = 0; m_count = 0;
      m_code = '0; m_lane = '0; m_first_code = '0; m_first_lane = '0;
      m_pcode = '0; m_plane = '0; m_pv = 1'b0; m_req = 1'b0;
      return;
    end
    f = m_pv && (m_pcode != 3'b000);
    m_req = 1'b0;
    if (clear_i) m_count = f ? 1 : 0;
    else if (f && m_count < CNT_MAX) m_count++;
    case (m_state)
      0: if (f) begin
        m_first_code = m_pcode;
        m_first_lane = m_plane;
        m_run = 1;
        if (PERSIST == 1) enter_fault(m_pcode, m_plane);
        else m_state = 1;
      end
      1: if (m_pv) begin
        if (f) begin
          m_run++;
          if (m_run >= PERSIST) enter_fault(m_first_code, m_first_lane);
        end else begin
          m_state = 0;
          m_run = 0;
        end
      end
      2: if (clear_i) begin
        m_state = 3;
        m_clean = 0;
      end
      default: if (m_pv) begin
        if (f) enter_fault(m_pcode, m_plane);
        else begin
          m_clean++;
          if (m_clean >= RECOV_CYC) begin
            m_state = 0; m_code = '0; m_lane = '0;
          end
        end
      end
    endcase
    classify(valid_i, opcode_i, reg_write_i, mem_read_i, mem_write_i, nc, nl);
    m_pv = valid_i;
    m_pcode = nc;
    m_plane = nl;
  endtask

  // Every-cycle comparison against the model, away from the active edge
  always @(negedge clk) begin
    if (chk_en) begin
      check("cyc_state",  32'(state_o),          32'(m_state));
      check("cyc_detect", 32'(fault_detected_o), 32'(m_state == 2));
      check("cyc_code",   32'(fault_code_o),     32'(m_code));
      check("cyc_lane",   32'(fault_lane_o),     32'(m_lane));
      check("cyc_count",  32'(fault_count_o),    32'(m_count));
      check("cyc_req",    32'(recover_req_o),    32'(m_req));
    end
  end

  // ---------------- stimulus ----------------
  task automatic tick();
    @(posedge clk);
    #1 model_step();
    @(negedge clk);
  endtask

  task automatic drive(input logic v, input logic [6:0] op0, input logic [6:0] op1,
                       input logic [1:0] rw, input logic [1:0] mr, input logic [1:0] mw,
                       input logic clr, input int n);
    valid_i     = v;
    opcode_i    = {op1, op0};
    reg_write_i = rw;
    mem_read_i  = mr;
    mem_write_i = mw;
    clear_i     = clr;
    repeat (n) tick();
  endtask

  task automatic clean(input int n);
    drive(1'b1, R, R, 2'b11, 2'b00, 2'b00, 1'b0, n);
  endtask

  initial begin
    rst_n = 1'b0;
    drive(1'b0, R, R, 2'b00, 2'b00, 2'b00, 1'b0, 2);
    chk_en = 1'b1;
    check("rst_state", 32'(state_o), 0);
    check("rst_count", 32'(fault_count_o), 0);
    check("rst_code",  32'(fault_code_o), 0);
    rst_n = 1'b1;

    // 1: clean R-type traffic
    clean(20);
    check("t1_state", 32'(state_o), 0);
    check("t1_count", 32'(fault_count_o), 0);

    // 2: single-cycle transient
    drive(1'b1, XX, R, 2'b11, 2'b00, 2'b00, 1'b0, 1);
    clean(1);
    check("t2_suspect", 32'(state_o), 1);
    clean(1);
    check("t2_back_ok", 32'(state_o), 0);
    check("t2_count", 32'(fault_count_o), 1);
    clean(2);

    // 3: illegal control on both lanes for two cycles
    drive(1'b1, LD, LD, 2'b11, 2'b11, 2'b11, 1'b0, 2);
    check("t3_after_e2", 32'(state_o), 1);
    clean(1);
    check("t3_detect", 32'(fault_detected_o), 1);
    check("t3_code",   32'(fault_code_o), 3'b010);
    check("t3_lane",   32'(fault_lane_o), 0);
    check("t3_req",    32'(recover_req_o), 1);
    check("t3_count",  32'(fault_count_o), 3);
    clean(1);
    check("t3_req_off", 32'(recover_req_o), 0);
    drive(1'b0, R, R, 2'b11, 2'b00, 2'b00, 1'b1, 1);
    clean(6);
    check("t3_recovered", 32'(state_o), 0);

    // 4: lane mismatch, clear, recovery boundary
    drive(1'b1, R, I, 2'b11, 2'b00, 2'b00, 1'b0, 2);
    clean(1);
    check("t4_state", 32'(state_o), 2);
    check("t4_code",  32'(fault_code_o), 3'b100);
    check("t4_lane",  32'(fault_lane_o), 1);
    drive(1'b1, R, R, 2'b11, 2'b00, 2'b00, 1'b1, 1);
    check("t4_recover", 32'(state_o), 3);
    check("t4_cleared", 32'(fault_count_o), 0);
    clean(3);
    check("t4_still_rec", 32'(state_o), 3);
    clean(1);
    check("t4_ok",      32'(state_o), 0);
    check("t4_code_0",  32'(fault_code_o), 0);
    check("t4_lane_0",  32'(fault_lane_o), 0);

    // 5: fault during RECOVER returns immediately
    drive(1'b1, XX, XX, 2'b11, 2'b00, 2'b00, 1'b0, 2);
    clean(1);
    check("t5_fault1", 32'(fault_code_o), 3'b001);
    drive(1'b1, R, R, 2'b11, 2'b00, 2'b00, 1'b1, 1);
    clean(1);
    drive(1'b1, R, XX, 2'b11, 2'b00, 2'b00, 1'b0, 1);
    clean(1);
    check("t5_refault", 32'(state_o), 2);
    check("t5_req",     32'(recover_req_o), 1);
    check("t5_code",    32'(fault_code_o), 3'b101);
    check("t5_lane",    32'(fault_lane_o), 1);
    check("t5_count",   32'(fault_count_o), 1);

    // clear and raw fault on the same edge: clear wins, then fault returns
    drive(1'b1, R, XX, 2'b11, 2'b00, 2'b00, 1'b0, 1);
    drive(1'b1, R, XX, 2'b11, 2'b00, 2'b00, 1'b1, 1);
    check("t5_clr_state", 32'(state_o), 3);
    check("t5_clr_count", 32'(fault_count_o), 1);
    clean(1);
    check("t5_back",     32'(state_o), 2);
    check("t5_back_req", 32'(recover_req_o), 1);

    // 6: saturation with valid gaps, then reset mid-SUSPECT
    rst_n = 1'b0;
    clean(1);
    rst_n = 1'b1;
    for (int i = 0; i < 5; i++) begin
      drive(1'b1, XX, XX, 2'b11, 2'b00, 2'b00, 1'b0, 1);
      drive(1'b0, XX, XX, 2'b11, 2'b00, 2'b00, 1'b0, 1);
      if (i == 0) check("t6_gap_hold", 32'(state_o), 1);
    end
    check("t6_sat",   32'(fault_count_o), 3);
    check("t6_state", 32'(state_o), 2);
    rst_n = 1'b0;
    clean(1);
    rst_n = 1'b1;
    drive(1'b1, XX, XX, 2'b11, 2'b00, 2'b00, 1'b0, 1);
    clean(1);
    check("t6_suspect", 32'(state_o), 1);
    rst_n = 1'b0;
    drive(1'b1, XX, XX, 2'b11, 2'b00, 2'b00, 1'b0, 1);
    check("t6_rst_state", 32'(state_o), 0);
    check("t6_rst_count", 32'(fault_count_o), 0);
    check("t6_rst_det",   32'(fault_detected_o), 0);
    rst_n = 1'b1;
    clean(3);
    check("t6_discard", 32'(state_o), 0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
    $finish;
  end

endmodule
